// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the MIPS ALU and its controller:
//                3-bit opcode encodings and the default datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default operand/result width of the datapath.
    localparam int c_DEFAULT_WIDTH = 32;

    // ALUcontrol opcode encodings.
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_NOR  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SUB  = 3'b111;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Combinational ALU datapath. One shared adder/subtractor
//                serves ADD, SUB, SLT and SLTU; logic ops are bitwise.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    i_srca     [WIDTH-1:0]  operand A
//    i_srcb     [WIDTH-1:0]  operand B
//    i_op       [2:0]        opcode (alu_pkg ALU_*)
//    o_result   [WIDTH-1:0]  result word
//    o_zero                  1 when o_result is all zeros
//    o_overflow              signed overflow of ADD/SUB
//                            (present only with ALU_OVERFLOW_EN)
//
//  Configuration macro: ALU_OVERFLOW_EN
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_srca,
    input  logic [WIDTH-1:0] i_srcb,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             o_overflow
`endif
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic             w_slt;
    logic             w_sltu;

    always_comb begin
        // Comparisons run through the subtractor: srca + ~srcb + 1.
        w_sub   = (i_op == ALU_SUB) || (i_op == ALU_SLT) || (i_op == ALU_SLTU);
        w_b_eff = w_sub ? ~i_srcb : i_srcb;
        w_sum   = {1'b0, i_srca} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};

        // Signed overflow: both addends share a sign that the sum does not.
        w_ovf   = (i_srca[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != i_srca[WIDTH-1]);

        // Sign of the difference corrected by overflow keeps SLT valid across
        // the sign boundary; a missing borrow (carry=1) means srca >= srcb.
        w_slt   = w_sum[WIDTH-1] ^ w_ovf;
        w_sltu  = ~w_sum[WIDTH];

        o_result = w_sum[WIDTH-1:0];
        case (i_op)
            ALU_AND:  o_result = i_srca & i_srcb;
            ALU_OR:   o_result = i_srca | i_srcb;
            ALU_ADD:  o_result = w_sum[WIDTH-1:0];
            ALU_XOR:  o_result = i_srca ^ i_srcb;
            ALU_NOR:  o_result = ~(i_srca | i_srcb);
            ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, w_sltu};
            ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_slt};
            ALU_SUB:  o_result = w_sum[WIDTH-1:0];
        endcase

        o_zero = (o_result == {WIDTH{1'b0}});
    end

`ifdef ALU_OVERFLOW_EN
    always_comb begin
        o_overflow = w_ovf && ((i_op == ALU_ADD) || (i_op == ALU_SUB));
    end
`endif

endmodule : alu_core
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : 32-bit integer ALU for the multi-cycle MIPS datapath.
//                Wraps alu_core with output registers (ALUOut stage);
//                results appear one clock after operands are presented.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk         rising-edge clock
//    reset       synchronous active-high reset
//    srca        [WIDTH-1:0] operand A
//    srcb        [WIDTH-1:0] operand B
//    ALUcontrol  [2:0]       opcode (alu_pkg ALU_*)
//    out         [WIDTH-1:0] registered result
//    zero        registered flag, 1 when out is all zeros
//    overflow    registered ADD/SUB signed overflow
//                (present only with ALU_OVERFLOW_EN)
//
//  Configuration macro: ALU_OVERFLOW_EN
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [2:0]       ALUcontrol,
    output logic [WIDTH-1:0] out,
    output logic             zero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    logic [WIDTH-1:0] w_core_result;
    logic             w_core_zero;
    logic [WIDTH-1:0] w_out_d;
    logic             w_zero_d;
    logic [WIDTH-1:0] r_out_q;
    logic             r_zero_q;

`ifdef ALU_OVERFLOW_EN
    logic w_core_overflow;
    logic w_overflow_d;
    logic r_overflow_q;
`endif

    alu_core #(
        .WIDTH      (WIDTH)
    ) u_alu_core (
        .i_srca     (srca),
        .i_srcb     (srcb),
        .i_op       (ALUcontrol),
        .o_result   (w_core_result),
        .o_zero     (w_core_zero)
`ifdef ALU_OVERFLOW_EN
        ,
        .o_overflow (w_core_overflow)
`endif
    );

    always_comb begin
        w_out_d  = w_core_result;
        w_zero_d = w_core_zero;
    end

    // Reset value keeps zero consistent with out == 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_q  <= {WIDTH{1'b0}};
            r_zero_q <= 1'b1;
        end else begin
            r_out_q  <= w_out_d;
            r_zero_q <= w_zero_d;
        end
    end

    assign out  = r_out_q;
    assign zero = r_zero_q;

`ifdef ALU_OVERFLOW_EN
    always_comb begin
        w_overflow_d = w_core_overflow;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow_q <= 1'b0;
        end else begin
            r_overflow_q <= w_overflow_d;
        end
    end

    assign overflow = r_overflow_q;
`endif

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu
//  Description : Self-checking bench for alu. A driver issues one operation
//                per cycle and queues the reference result; a monitor pops
//                and compares one entry just after every rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] srca = '0;
    logic [W-1:0] srcb = '0;
    logic [2:0]   ALUcontrol = 3'b000;
    logic [W-1:0] out;
    logic         zero;
`ifdef ALU_OVERFLOW_EN
    logic         overflow;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] out;
        logic         zero;
        logic         ovf;
        string        name;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu #(
        .WIDTH      (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .srca       (srca),
        .srcb       (srcb),
        .ALUcontrol (ALUcontrol),
        .out        (out),
        .zero       (zero)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    // Reference result from the opcode definitions using plain arithmetic.
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic [2:0]   op);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a ^ b;
            3'd4: return ~(a | b);
            3'd5: return (a < b) ? 32'd1 : 32'd0;
            3'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a - b;
        endcase
    endfunction

    // Signed overflow: the exact signed result leaves the 32-bit range.
    function automatic logic ref_ovf(input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     input logic [2:0]   op);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 3'd2)      r = sa + sb;
        else if (op == 3'd7) r = sa - sb;
        else                 return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic rst, input string nm);
        exp_t e;
        @(negedge clk);
        srca       = a;
        srcb       = b;
        ALUcontrol = op;
        reset      = rst;
        if (rst) begin
            e.out = '0;
            e.ovf = 1'b0;
        end else begin
            e.out = ref_result(a, b, op);
            e.ovf = ref_ovf(a, b, op);
        end
        e.zero = (e.out == 0);
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: one queued expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out !== e.out) begin
                    failures++;
                    $display("FAIL %s out: got %h expected %h", e.name, out, e.out);
                end
                checks++;
                if (zero !== e.zero) begin
                    failures++;
                    $display("FAIL %s zero: got %b expected %b", e.name, zero, e.zero);
                end
`ifdef ALU_OVERFLOW_EN
                checks++;
                if (overflow !== e.ovf) begin
                    failures++;
                    $display("FAIL %s overflow: got %b expected %b", e.name, overflow, e.ovf);
                end
`endif
            end
        end
    end

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset for two cycles with random operands.
        issue($urandom, $urandom, 3'($urandom_range(0, 7)), 1'b1, "reset0");
        issue($urandom, $urandom, 3'($urandom_range(0, 7)), 1'b1, "reset1");

        // Subtract / equality.
        issue(32'd15, 32'd15, 3'b111, 1'b0, "sub_eq");
        issue(32'd15, 32'd16, 3'b111, 1'b0, "sub_neg");
        issue(32'd16, 32'd15, 3'b111, 1'b0, "sub_one");
        issue(32'd0,  32'd1,  3'b111, 1'b0, "sub_0m1");

        // Logic ops.
        issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 1'b0, "and");
        issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 1'b0, "or");
        issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 1'b0, "xor");
        issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 1'b0, "nor");

        // Add wrap and signed overflow.
        issue(32'hFFFF_FFFF, 32'd1, 3'b010, 1'b0, "add_wrap");
        issue(32'h7FFF_FFFF, 32'd1, 3'b010, 1'b0, "add_ovf");
        issue(32'h8000_0000, 32'd1, 3'b111, 1'b0, "sub_ovf");

        // Compares across the sign boundary.
        issue(32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 1'b0, "slt_neg_pos");
        issue(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1'b0, "sltu_neg_pos");
        issue(32'h7FFF_FFFF, 32'h8000_0000, 3'b110, 1'b0, "slt_pos_neg");
        issue(32'h7FFF_FFFF, 32'h8000_0000, 3'b101, 1'b0, "sltu_pos_neg");
        issue(32'h8000_0000, 32'h8000_0000, 3'b110, 1'b0, "slt_eq");
        issue(32'h8000_0000, 32'h8000_0000, 3'b101, 1'b0, "sltu_eq");

        // Back-to-back random ops with a mid-sequence reset.
        for (int i = 0; i < 16; i++) begin
            issue($urandom, $urandom, 3'(i % 8), (i == 9) ? 1'b1 : 1'b0,
                  (i == 9) ? "b2b_reset" : "b2b");
        end

        // Broader random sweep with boundary-biased operands.
        for (int i = 0; i < 300; i++) begin
            issue(pick_operand(), pick_operand(), 3'($urandom_range(0, 7)), 1'b0, "rand");
        end

        // Drain the scoreboard with a bounded wait.
        @(negedge clk);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries outstanding, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu
`default_nettype wire

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the multi-cycle MIPS datapath.
- Takes two operands and a 3-bit operation code, and produces a result word and a zero flag.
- Outputs are registered: the result appears one clock after the operands are presented, as the multi-cycle ALUOut stage needs.
- The zero flag feeds branch-equal decisions in the controller.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be 2 or more.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- srca  input  WIDTH  operand A.
- srcb  input  WIDTH  operand B.
- ALUcontrol  input  3  operation select.
- out  output  WIDTH  registered result.
- zero  output  1  registered flag; 1 when out is all zeros.

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-high, named reset.
- Reset: on a rising edge with reset=1, out becomes 0 and zero becomes 1. Reset takes priority over any operation.
- Invariant: zero == (out == 0) in every cycle, including directly after reset.
- Latency: exactly 1 cycle.
  - srca, srcb and ALUcontrol are sampled on each rising edge with reset=0.
  - out and zero update on that same edge.
  - There is no handshake; an operation issues every cycle.
  - Outputs hold until the next edge.
- Opcode map (ALUcontrol):
  - 000 AND: srca & srcb.
  - 001 OR: srca | srcb.
  - 010 ADD: srca + srcb, modulo 2^WIDTH.
  - 011 XOR: srca ^ srcb.
  - 100 NOR: ~(srca | srcb).
  - 101 SLTU: 1 if srca < srcb as unsigned, else 0. Result is zero-extended to WIDTH.
  - 110 SLT: 1 if srca < srcb as two's-complement signed, else 0. Result is zero-extended to WIDTH.
  - 111 SUB: srca − srcb, modulo 2^WIDTH. Implemented as srca + ~srcb + 1.
- Arithmetic rules:
  - Carry-out and overflow are discarded; results wrap.
  - SLT must be correct across sign boundaries. Compute it from the sign of the difference XOR the signed-overflow bit, not from the raw sign alone.
- Boundary cases:
  - 0x7FFFFFFF + 1 = 0x80000000, zero=0.
  - 0xFFFFFFFF + 1 = 0, zero=1.
  - 0 − 1 = 0xFFFFFFFF.
  - SLT(0x80000000, 0x7FFFFFFF) = 1.
  - SLTU of the same operands = 0.
  - Equal operands under SUB give out=0, zero=1.
- Unknown or X opcode: cannot occur, since all 8 codes are defined.
- Reset asserted mid-stream: the next edge clears the outputs, and the operation sampled on that edge is lost.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- When defined:
  - An extra output port overflow (1 bit, registered, same latency) is added.
  - It is 1 when ADD or SUB produces signed two's-complement overflow, and 0 for all other opcodes.
  - It resets to 0.
- When undefined:
  - The port is absent.
  - Overflow logic is not synthesised.
  - All other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - 3-bit opcode localparams ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_NOR, ALU_SLTU, ALU_SLT, ALU_SUB.
  - Default WIDTH constant.
  - The controller uses the same package.
- One natural sub-module: alu_core.
  - Purely combinational; computes the result, zero and overflow from the operands and opcode.
  - It contains the shared adder/subtractor used by ADD, SUB, SLT and SLTU.
  - The top alu wraps it with the output registers and reset.

Test Plan:
- Reset: reset=1 for 2 cycles with random operands -> out=0, zero=1. After release, the first result appears one edge after the operands are applied.
- Subtract, equal operands:
  - srca=15, srcb=15, op=111 -> out=0, zero=1.
  - Then srcb=16 -> next cycle out=0xFFFFFFFF, zero=0.
  - Then srca=16, srcb=15 -> out=1, zero=0.
- Logic ops with srca=0xF0F0F0F0, srcb=0xFF00FF00:
  - AND = 0xF000F000.
  - OR = 0xFFF0FFF0.
  - XOR = 0x0FF00FF0.
  - NOR = 0x000F000F.
- Add wrap: 0xFFFFFFFF + 1 -> out=0, zero=1. 0x7FFFFFFF + 1 -> 0x80000000 (overflow=1 with ALU_OVERFLOW_EN).
- Compare with srca=0x80000000, srcb=0x7FFFFFFF:
  - SLT -> 1.
  - SLTU -> 0.
  - Swapped operands -> SLT 0, SLTU 1.
  - Equal operands -> both 0, zero=1.
- Back-to-back pipelining: change the opcode every cycle for 16 random cycles -> each out matches the reference model of the previous cycle's inputs. Reset asserted mid-sequence clears the outputs on the next edge.
